solution_assembler: RTL and testbench

- Serialises a solved nonogram grid (up to 11x11) into a byte stream for a UART-style transmitter.
- Sits between the solver output and the byte transmitter.
- Latches the solution, then emits 16-bit messages as byte pairs, high byte first: M header, N header, one message per row, then STOP.
- Each byte is handed off with a one-cycle `send` strobe; the block waits for the transmitter's `transmit_done` before the next byte.

---
 rtl/solution_assembler.sv | 175 +++++++++++++++++
 tb/tb_solution_assembler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/solution_assembler.sv
// Serialises a latched nonogram solution into 16-bit messages sent as byte pairs
// (M header, N header, one message per row, STOP) with a send/transmit_done handshake.
module solution_assembler #(
    parameter int unsigned MAX_DIM = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         transmit_done,
    input  logic [MAX_DIM*MAX_DIM-1:0]   solution,
    input  logic [3:0]                   m,
    input  logic [3:0]                   n,
    output logic                         send,
    output logic [7:0]                   byte_out,
    output logic                         done
);

    localparam int unsigned DIM_W  = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned MSG_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND_HI,
        S_WAIT_HI,
        S_SEND_LO,
        S_WAIT_LO,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [DIM_W-1:0]      m_q;
    logic [DIM_W-1:0]      n_q;
    logic [MAX_DIM-1:0]    rows_q [MAX_DIM];
    logic [IDX_W-1:0]      idx;
    logic                  td_prev;

    logic [DIM_W-1:0]      m_clamp_c;
    logic [DIM_W-1:0]      n_clamp_c;
    logic [MAX_DIM-1:0]    col_mask_c;
    logic                  td_rise_c;
    logic [MSG_W-1:0]      msg_c;
    logic [IDX_W-1:0]      msgs_end_c;

    logic                  send_d;
    logic                  done_d;
    logic [BYTE_W-1:0]     byte_d;

    // Dimension clamping and column mask applied at latch time
    assign m_clamp_c = (m > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : m;
    assign n_clamp_c = (n > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : n;

    always_comb begin
        col_mask_c = '0;
        for (int c = 0; c < int'(MAX_DIM); c++) begin
            col_mask_c[c] = (DIM_W'(c) < n_clamp_c);
        end
    end

    assign td_rise_c  = transmit_done & ~td_prev;
    // Index one past STOP: 2 headers + m rows + STOP
    assign msgs_end_c = IDX_W'(m_q) + IDX_W'(3);

    // Solution latch, only accepted while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= '0;
            n_q <= '0;
            for (int r = 0; r < int'(MAX_DIM); r++) begin
                rows_q[r] <= '0;
            end
        end else if (state == S_IDLE && valid_in) begin
            m_q <= m_clamp_c;
            n_q <= n_clamp_c;
            for (int r = 0; r < int'(MAX_DIM); r++) begin
                rows_q[r] <= solution[r*MAX_DIM +: MAX_DIM] & col_mask_c;
            end
        end
    end

    // Message index advances when the low byte of a message completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (state == S_IDLE) begin
            idx <= '0;
        end else if (state == S_WAIT_LO && td_rise_c) begin
            idx <= idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            td_prev <= 1'b0;
        end else begin
            td_prev <= transmit_done;
        end
    end

    // Message selected by the current index; STOP beyond the last row
    always_comb begin
        msg_c = '0;
        if (idx == IDX_W'(0)) begin
            msg_c = {3'b111, 1'b0, 8'h00, m_q};
        end else if (idx == IDX_W'(1)) begin
            msg_c = {3'b111, 1'b1, 8'h00, n_q};
        end else begin
            for (int r = 0; r < int'(MAX_DIM); r++) begin
                if (idx == IDX_W'(r + 2) && DIM_W'(r) < m_q) begin
                    msg_c = {1'b0, 4'(r + 1), rows_q[r]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (valid_in) next_state = S_LOAD;
            S_LOAD:    next_state = S_SEND_HI;
            S_SEND_HI: next_state = S_WAIT_HI;
            S_WAIT_HI: if (td_rise_c) next_state = S_SEND_LO;
            S_SEND_LO: next_state = S_WAIT_LO;
            S_WAIT_LO: if (td_rise_c) next_state = S_NEXT;
            S_NEXT:    next_state = (idx == msgs_end_c) ? S_DONE : S_SEND_HI;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered below
    always_comb begin
        send_d = 1'b0;
        done_d = 1'b0;
        byte_d = byte_out;
        case (next_state)
            S_SEND_HI: begin
                send_d = 1'b1;
                byte_d = msg_c[15:8];
            end
            S_SEND_LO: begin
                send_d = 1'b1;
                byte_d = msg_c[7:0];
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send     <= 1'b0;
            done     <= 1'b0;
            byte_out <= '0;
        end else begin
            send     <= send_d;
            done     <= done_d;
            byte_out <= byte_d;
        end
    end

endmodule

// File: tb/tb_solution_assembler.sv
// Scoreboard bench for solution_assembler: directed grids, transmitter model with
// configurable done timing, handshake robustness and mid-transfer reset.
module tb_solution_assembler;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         transmit_done;
    logic [120:0] solution;
    logic [3:0]   m;
    logic [3:0]   n;
    logic         send;
    logic [7:0]   byte_out;
    logic         done;

    logic         tx_level = 1'b0;
    logic         man_td   = 1'b0;
    bit           tx_en    = 1'b1;
    int           tx_delay = 3;
    int           tx_hold  = 2;
    int           dly      = 0;
    int           hold     = 0;

    int           compares   = 0;
    int           errors     = 0;
    int           sends_seen = 0;
    int           done_cnt   = 0;
    logic [7:0]   exp_q [$];
    logic [7:0]   exp_b;

    localparam logic [120:0] SOL3 = {88'b0, 33'b000000001010000000001000000000011};
    localparam logic [120:0] ONES = '1;

    assign transmit_done = tx_level | man_td;

    solution_assembler #(.MAX_DIM(11)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .transmit_done (transmit_done),
        .solution      (solution),
        .m             (m),
        .n             (n),
        .send          (send),
        .byte_out      (byte_out),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes send
    always @(negedge clk) begin
        if (send) begin
            sends_seen++;
            if (exp_q.size() == 0) begin
                compares++;
                errors++;
                $display("FAIL unexpected_send: byte %02h sent, none expected (t=%0t)", byte_out, $time);
            end else begin
                exp_b = exp_q.pop_front();
                check("byte_out", 32'(byte_out), 32'(exp_b));
            end
        end
        if (done) done_cnt++;
    end

    // Transmitter model: done rises tx_delay cycles after send, held tx_hold cycles
    always @(negedge clk) begin
        if (!rst) begin
            dly      = 0;
            hold     = 0;
            tx_level = 1'b0;
        end else begin
            if (dly > 0) begin
                dly--;
                if (dly == 0) hold = tx_hold;
            end
            if (hold > 0) begin
                tx_level = 1'b1;
                hold--;
            end else begin
                tx_level = 1'b0;
            end
            if (send) begin
                check("send_after_prev_done", 32'(dly == 0), 32'd1);
                if (tx_en) dly = tx_delay;
            end
        end
    end

    task automatic push_msg(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic clear_counts();
        exp_q.delete();
        sends_seen = 0;
        done_cnt   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        man_td   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_counts();
    endtask

    task automatic start(input logic [120:0] s, input logic [3:0] mm, input logic [3:0] nn);
        @(negedge clk);
        solution = s;
        m        = mm;
        n        = nn;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (4) @(negedge clk);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_done_once"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic wait_sends(input string name, input int target, input int budget);
        for (int i = 0; i < budget && sends_seen < target; i++) @(negedge clk);
        check({name, "_sends_reached"}, 32'(sends_seen >= target), 32'd1);
    endtask

    task automatic push_3x3();
        push_msg(16'hE003);
        push_msg(16'hF003);
        push_msg(16'h0803);
        push_msg(16'h1002);
        push_msg(16'h1805);
        push_msg(16'h0000);
    endtask

    initial begin
        rst      = 1'b0;
        valid_in = 1'b0;
        solution = '0;
        m        = '0;
        n        = '0;
        #1;
        check("reset_send", 32'(send), 32'd0);
        check("reset_byte_out", 32'(byte_out), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // 3x3 grid with first-send latency, then stray transmit_done pulses
        do_reset();
        push_3x3();
        start(SOL3, 4'd3, 4'd3);
        check("latency_load_no_send", 32'(send), 32'd0);
        @(negedge clk);
        check("latency_first_send", 32'(send), 32'd1);
        wait_done("grid3", 1000);
        check("grid3_send_count", 32'(sends_seen), 32'd12);
        repeat (3) begin
            man_td = 1'b1;
            repeat (2) @(negedge clk);
            man_td = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("grid3_extra_td_sends", 32'(sends_seen), 32'd12);
        check("grid3_extra_td_done", 32'(done_cnt), 32'd1);

        // Masking, with transmit_done held 5 cycles per byte
        do_reset();
        tx_hold  = 5;
        tx_delay = 6;
        push_msg(16'hE002);
        push_msg(16'hF002);
        push_msg(16'h0803);
        push_msg(16'h1003);
        push_msg(16'h0000);
        start(ONES, 4'd2, 4'd2);
        wait_done("mask2", 2000);
        check("mask2_send_count", 32'(sends_seen), 32'd10);
        tx_hold  = 2;
        tx_delay = 3;

        // Full 11x11 grid
        do_reset();
        push_msg(16'hE00B);
        push_msg(16'hF00B);
        for (int r = 0; r < 11; r++) push_msg(16'h0FFF + 16'(r * 16'h0800));
        push_msg(16'h0000);
        start(ONES, 4'd11, 4'd11);
        wait_done("grid11", 3000);
        check("grid11_send_count", 32'(sends_seen), 32'd28);

        // m=0 gives headers then STOP; n above 11 clamps
        do_reset();
        push_msg(16'hE000);
        push_msg(16'hF00B);
        push_msg(16'h0000);
        start(ONES, 4'd0, 4'd15);
        wait_done("m0_clamp", 1000);
        check("m0_clamp_send_count", 32'(sends_seen), 32'd6);

        // valid_in mid-transfer is ignored
        do_reset();
        push_3x3();
        start(SOL3, 4'd3, 4'd3);
        wait_sends("midvalid", 3, 500);
        start(ONES, 4'd11, 4'd11);
        wait_done("midvalid", 1000);
        check("midvalid_send_count", 32'(sends_seen), 32'd12);

        // No transmit_done: stream stalls on the first byte
        do_reset();
        tx_en = 1'b0;
        exp_q.push_back(8'hE0);
        start(SOL3, 4'd3, 4'd3);
        wait_sends("stall", 1, 100);
        repeat (20) @(negedge clk);
        check("stall_send_count", 32'(sends_seen), 32'd1);
        check("stall_byte_stable", 32'(byte_out), 32'hE0);
        check("stall_no_done", 32'(done_cnt), 32'd0);
        tx_en = 1'b1;

        // Asynchronous reset after the 4th byte, then a clean restart
        do_reset();
        push_msg(16'hE003);
        push_msg(16'hF003);
        start(SOL3, 4'd3, 4'd3);
        wait_sends("rstmid", 4, 500);
        #2 rst = 1'b0;
        #1;
        check("rstmid_send", 32'(send), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_byte_out", 32'(byte_out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);
        clear_counts();
        repeat (3) @(negedge clk);
        check("rstmid_no_resume", 32'(sends_seen), 32'd0);
        push_3x3();
        start(SOL3, 4'd3, 4'd3);
        wait_done("rstmid_restart", 1000);
        check("rstmid_restart_count", 32'(sends_seen), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
